// File: rtl/cgra_config_loader_if.sv
// Configuration word stream between a config source and the CGRA loader.
//   cfg_valid       : source has a config word on the field lines
//   cfg_ready       : loader will take the word on the next rising edge
//   cfg_pe_id       : target PE of the word
//   cfg_index       : context slot inside the PE
//   cfg_input_pe_1/2: operand-source selects
//   cfg_op          : opcode
//   cfg_const       : constant operand
// Modports: master = config source, slave = loader.
interface cgra_config_loader_if #(
   parameter int PE_ID_WIDTH        = 4,
   parameter int CONTEXT_IDX_WIDTH  = 2,
   parameter int NEIGHBOR_SEL_WIDTH = 3,
   parameter int OP_WIDTH           = 4,
   parameter int DATA_WIDTH         = 32
);
   logic                          cfg_valid;
   logic                          cfg_ready;
   logic [PE_ID_WIDTH-1:0]        cfg_pe_id;
   logic [CONTEXT_IDX_WIDTH-1:0]  cfg_index;
   logic [NEIGHBOR_SEL_WIDTH-1:0] cfg_input_pe_1;
   logic [NEIGHBOR_SEL_WIDTH-1:0] cfg_input_pe_2;
   logic [OP_WIDTH-1:0]           cfg_op;
   logic [DATA_WIDTH-1:0]         cfg_const;

   modport master (
      output cfg_valid, cfg_pe_id, cfg_index, cfg_input_pe_1, cfg_input_pe_2,
             cfg_op, cfg_const,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_pe_id, cfg_index, cfg_input_pe_1, cfg_input_pe_2,
             cfg_op, cfg_const,
      output cfg_ready
   );
endinterface

// File: rtl/cgra_config_loader.sv
// CGRA configuration loader: takes PE_NUM*CONTEXT_NUM config words from a
// valid/ready stream, writes each to its PE through a one-hot strobe with
// broadcast fields, then pulses a context-counter restart and enters RUN.
//   clk, reset_n       : clock (rising edge), asynchronous active-low reset
//   start, abort       : begin a load / cancel load or run (abort wins)
//   cfg                : config word stream (slave side)
//   pe_write           : one-hot per-PE write strobe, one cycle per word
//   pe_config_index .. pe_const : registered broadcast fields of that word
//   pe_config_reset    : one-cycle restart pulse after the last word
//   busy, done, error  : status (error = out-of-range PE id seen)
module cgra_config_loader #(
   parameter int PE_NUM             = 16,
   parameter int PE_ID_WIDTH        = 4,
   parameter int CONTEXT_NUM        = 4,
   parameter int CONTEXT_IDX_WIDTH  = 2,
   parameter int NEIGHBOR_SEL_WIDTH = 3,
   parameter int OP_WIDTH           = 4,
   parameter int DATA_WIDTH         = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          abort,
   cgra_config_loader_if.slave           cfg,
   output logic [PE_NUM-1:0]             pe_write,
   output logic [CONTEXT_IDX_WIDTH-1:0]  pe_config_index,
   output logic [NEIGHBOR_SEL_WIDTH-1:0] pe_input_pe_1,
   output logic [NEIGHBOR_SEL_WIDTH-1:0] pe_input_pe_2,
   output logic [OP_WIDTH-1:0]           pe_op,
   output logic [DATA_WIDTH-1:0]         pe_const,
   output logic                          pe_config_reset,
   output logic                          busy,
   output logic                          done,
   output logic                          error
);

   localparam int TOTAL_WORDS = PE_NUM * CONTEXT_NUM;
   localparam int CNT_WIDTH   = $clog2(TOTAL_WORDS + 1);
   localparam logic [CNT_WIDTH-1:0]   TOTAL_CNT = CNT_WIDTH'(TOTAL_WORDS);
   // One extra bit so PE_NUM itself is representable for the range check.
   localparam logic [PE_ID_WIDTH:0]   PE_LIMIT  = (PE_ID_WIDTH + 1)'(PE_NUM);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FLUSH = 3'd2,
      PULSE = 3'd3,
      RUN   = 3'd4
   } state_t;

   state_t                          state_r, state_next_s;
   logic [CNT_WIDTH-1:0]            word_cnt_r, word_cnt_next_s;
   logic                            error_r, error_next_s;
   logic                            id_ok_s;
   logic                            load_word_s;
   logic [PE_NUM-1:0]               pe_write_r, pe_write_next_s;
   logic [CONTEXT_IDX_WIDTH-1:0]    pe_config_index_r;
   logic [NEIGHBOR_SEL_WIDTH-1:0]   pe_input_pe_1_r, pe_input_pe_2_r;
   logic [OP_WIDTH-1:0]             pe_op_r;
   logic [DATA_WIDTH-1:0]           pe_const_r;
   logic                            pe_config_reset_r, busy_r, done_r;

   // Ready is a pure state decode so the source sees it in the same cycle.
   assign cfg.cfg_ready = (state_r == LOAD);

   // State, word counter and sticky error register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         word_cnt_r <= '0;
         error_r    <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         word_cnt_r <= word_cnt_next_s;
         error_r    <= error_next_s;
      end
   end

   // Next-state, counter/error update and word-accept decode.
   always_comb begin
      state_next_s    = state_r;
      word_cnt_next_s = word_cnt_r;
      error_next_s    = error_r;
      load_word_s     = 1'b0;
      id_ok_s         = ({1'b0, cfg.cfg_pe_id} < PE_LIMIT);
      if (abort) begin
         // Abort overrides everything, including a word offered this cycle.
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_next_s    = LOAD;
                  word_cnt_next_s = '0;
                  error_next_s    = 1'b0;
               end else begin
                  state_next_s = IDLE;
               end
            end
            LOAD: begin
               if (cfg.cfg_valid) begin
                  if (id_ok_s) begin
                     load_word_s     = 1'b1;
                     word_cnt_next_s = word_cnt_r + CNT_WIDTH'(1);
                     if (word_cnt_next_s == TOTAL_CNT) begin
                        state_next_s = FLUSH;
                     end else begin
                        state_next_s = LOAD;
                     end
                  end else begin
                     // Out-of-range PE: drop the word, do not count it.
                     error_next_s = 1'b1;
                  end
               end else begin
                  state_next_s = LOAD;
               end
            end
            FLUSH:   state_next_s = PULSE;
            PULSE:   state_next_s = RUN;
            RUN: begin
               if (start) begin
                  state_next_s    = LOAD;
                  word_cnt_next_s = '0;
                  error_next_s    = 1'b0;
               end else begin
                  state_next_s = RUN;
               end
            end
            default: state_next_s = IDLE;
         endcase
      end
   end

   // One-hot strobe for the accepted word; all zero when nothing is taken.
   always_comb begin
      pe_write_next_s = '0;
      for (int i = 0; i < PE_NUM; i++) begin
         pe_write_next_s[i] = load_word_s && (cfg.cfg_pe_id == PE_ID_WIDTH'(i));
      end
   end

   // Registered PE-side outputs; status is decoded from the next state so it
   // lines up with state_r without a combinational output path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pe_write_r        <= '0;
         pe_config_index_r <= '0;
         pe_input_pe_1_r   <= '0;
         pe_input_pe_2_r   <= '0;
         pe_op_r           <= '0;
         pe_const_r        <= '0;
         pe_config_reset_r <= 1'b0;
         busy_r            <= 1'b0;
         done_r            <= 1'b0;
      end else begin
         pe_write_r <= pe_write_next_s;
         if (load_word_s) begin
            pe_config_index_r <= cfg.cfg_index;
            pe_input_pe_1_r   <= cfg.cfg_input_pe_1;
            pe_input_pe_2_r   <= cfg.cfg_input_pe_2;
            pe_op_r           <= cfg.cfg_op;
            pe_const_r        <= cfg.cfg_const;
         end
         pe_config_reset_r <= (state_next_s == PULSE);
         busy_r            <= (state_next_s == LOAD) || (state_next_s == FLUSH) ||
                              (state_next_s == PULSE);
         done_r            <= (state_next_s == RUN);
      end
   end

   assign pe_write        = pe_write_r;
   assign pe_config_index = pe_config_index_r;
   assign pe_input_pe_1   = pe_input_pe_1_r;
   assign pe_input_pe_2   = pe_input_pe_2_r;
   assign pe_op           = pe_op_r;
   assign pe_const        = pe_const_r;
   assign pe_config_reset = pe_config_reset_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign error           = error_r;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Self-checking bench for cgra_config_loader. PE_ID_WIDTH is widened to 5 so
// an out-of-range PE id (20) can be presented with PE_NUM = 16.
module tb_cgra_config_loader;
   localparam int PE_NUM = 16;
   localparam int PIDW   = 5;
   localparam int CTXN   = 4;
   localparam int CIW    = 2;
   localparam int NSW    = 3;
   localparam int OPW    = 4;
   localparam int DW     = 32;

   typedef struct {
      int          due;
      logic [15:0] pw;
      logic [1:0]  idx;
      logic [2:0]  in1;
      logic [2:0]  in2;
      logic [3:0]  op;
      logic [31:0] cst;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] pe_write;
   logic [1:0]  pe_config_index;
   logic [2:0]  pe_input_pe_1, pe_input_pe_2;
   logic [3:0]  pe_op;
   logic [31:0] pe_const;
   logic        pe_config_reset, busy, done, error;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t sb[$];

   // monitor-private expectation state
   exp_t        m_e;
   logic [15:0] m_pw;
   logic [1:0]  m_idx = 2'd0;
   logic [2:0]  m_in1 = 3'd0, m_in2 = 3'd0;
   logic [3:0]  m_op = 4'd0;
   logic [31:0] m_cst = 32'd0;

   cgra_config_loader_if #(.PE_ID_WIDTH(PIDW), .CONTEXT_IDX_WIDTH(CIW),
      .NEIGHBOR_SEL_WIDTH(NSW), .OP_WIDTH(OPW), .DATA_WIDTH(DW)) bus ();

   cgra_config_loader #(.PE_NUM(PE_NUM), .PE_ID_WIDTH(PIDW), .CONTEXT_NUM(CTXN),
      .CONTEXT_IDX_WIDTH(CIW), .NEIGHBOR_SEL_WIDTH(NSW), .OP_WIDTH(OPW),
      .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cfg(bus),
      .pe_write(pe_write), .pe_config_index(pe_config_index),
      .pe_input_pe_1(pe_input_pe_1), .pe_input_pe_2(pe_input_pe_2),
      .pe_op(pe_op), .pe_const(pe_const), .pe_config_reset(pe_config_reset),
      .busy(busy), .done(done), .error(error));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every cycle pe_write must equal the entry due now
   // (or zero), and broadcast fields must equal the last written word.
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         m_idx = 2'd0; m_in1 = 3'd0; m_in2 = 3'd0; m_op = 4'd0; m_cst = 32'd0;
         vectors++;
         if (pe_write !== 16'h0000) begin
            miscompares++;
            $display("FAIL sb_reset_pe_write: got %h, expected 0000", pe_write);
         end
      end else begin
         m_pw = 16'h0000;
         while (sb.size() > 0 && sb[0].due < cyc) begin
            m_e = sb.pop_front();
            miscompares++;
            $display("FAIL sb_missed: write due at cycle %0d not seen (now %0d)", m_e.due, cyc);
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            m_e   = sb.pop_front();
            m_pw  = m_e.pw;  m_idx = m_e.idx; m_in1 = m_e.in1;
            m_in2 = m_e.in2; m_op  = m_e.op;  m_cst = m_e.cst;
         end
         vectors++;
         if (pe_write !== m_pw || pe_config_index !== m_idx || pe_input_pe_1 !== m_in1 ||
             pe_input_pe_2 !== m_in2 || pe_op !== m_op || pe_const !== m_cst) begin
            miscompares++;
            $display("FAIL sb_word cyc %0d: got pw=%h idx=%0d i1=%0d i2=%0d op=%h c=%h, expected pw=%h idx=%0d i1=%0d i2=%0d op=%h c=%h",
                     cyc, pe_write, pe_config_index, pe_input_pe_1, pe_input_pe_2, pe_op, pe_const,
                     m_pw, m_idx, m_in1, m_in2, m_op, m_cst);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one word for one cycle; push the expected write if it should land.
   task automatic drive_word(input logic [4:0] pe, input logic [1:0] idx,
                             input logic [2:0] i1, input logic [2:0] i2,
                             input logic [3:0] op, input logic [31:0] cst,
                             input bit acc);
      exp_t e;
      bus.cfg_valid = 1'b1;      bus.cfg_pe_id = pe;        bus.cfg_index = idx;
      bus.cfg_input_pe_1 = i1;   bus.cfg_input_pe_2 = i2;   bus.cfg_op = op;
      bus.cfg_const = cst;
      if (acc && int'(pe) < PE_NUM) begin
         e.due = cyc + 1; e.pw = 16'h0001 << pe; e.idx = idx;
         e.in1 = i1; e.in2 = i2; e.op = op; e.cst = cst;
         sb.push_back(e);
      end
      tick();
   endtask

   task automatic drive_k(input int k, input bit acc);
      drive_word(5'(k % 16), 2'(k / 16), 3'(k % 8), 3'((k + 3) % 8),
                 4'((k * 7) % 16), $urandom, acc);
   endtask

   task automatic test_reset();
      bus.cfg_valid = 1'b0; bus.cfg_pe_id = 5'd0; bus.cfg_index = 2'd0;
      bus.cfg_input_pe_1 = 3'd0; bus.cfg_input_pe_2 = 3'd0; bus.cfg_op = 4'd0;
      bus.cfg_const = 32'd0;
      reset_n = 1'b0;
      tick(); tick();
      vectors++;
      if ({pe_write, pe_config_index, pe_input_pe_1, pe_input_pe_2, pe_op, pe_const,
           pe_config_reset, busy, done, error, bus.cfg_ready} !== 70'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got pw=%h rst=%b busy=%b done=%b err=%b rdy=%b, expected all 0",
                  pe_write, pe_config_reset, busy, done, error, bus.cfg_ready);
      end
      #2 reset_n = 1'b1;
      tick();
      vectors++;
      if (bus.cfg_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b, expected 0 0 0",
                  bus.cfg_ready, busy, done);
      end
   endtask

   task automatic test_full_load();
      start = 1'b1; tick(); start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || bus.cfg_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL load_entry: got busy=%b rdy=%b done=%b, expected 1 1 0", busy, bus.cfg_ready, done);
      end
      for (int k = 0; k < 64; k++) drive_k(k, 1'b1);
      bus.cfg_valid = 1'b0;
      vectors++;
      if (bus.cfg_ready !== 1'b0 || busy !== 1'b1 || pe_config_reset !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_state: got rdy=%b busy=%b cfgrst=%b, expected 0 1 0",
                  bus.cfg_ready, busy, pe_config_reset);
      end
      tick();
      vectors++;
      if (pe_config_reset !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL pulse_state: got cfgrst=%b busy=%b done=%b, expected 1 1 0",
                  pe_config_reset, busy, done);
      end
      tick();
      vectors++;
      if (pe_config_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL run_state: got cfgrst=%b done=%b busy=%b err=%b, expected 0 1 0 0",
                  pe_config_reset, done, busy, error);
      end
      repeat (3) tick();
      vectors++;
      if (done !== 1'b1 || bus.cfg_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL run_hold: got done=%b rdy=%b, expected 1 0", done, bus.cfg_ready);
      end
   endtask

   task automatic test_bad_id();
      start = 1'b1; tick(); start = 1'b0;
      vectors++;
      if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_from_run: got done=%b err=%b busy=%b, expected 0 0 1", done, error, busy);
      end
      for (int k = 0; k < 30; k++) drive_k(k, 1'b1);
      drive_word(5'd20, 2'd1, 3'd2, 3'd3, 4'hF, 32'hDEAD_BEEF, 1'b1);
      vectors++;
      if (error !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_id_error: got err=%b, expected 1", error);
      end
      start = 1'b1;
      drive_k(30, 1'b1);
      start = 1'b0;
      for (int k = 31; k < 63; k++) drive_k(k, 1'b1);
      vectors++;
      if (bus.cfg_ready !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL count_after_63: got rdy=%b busy=%b, expected 1 1", bus.cfg_ready, busy);
      end
      drive_k(63, 1'b1);
      bus.cfg_valid = 1'b0;
      vectors++;
      if (bus.cfg_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_id_flush: got rdy=%b, expected 0", bus.cfg_ready);
      end
      tick();
      vectors++;
      if (pe_config_reset !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_id_pulse: got cfgrst=%b, expected 1", pe_config_reset);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || error !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_id_run: got done=%b err=%b, expected 1 1", done, error);
      end
   endtask

   task automatic test_valid_toggle();
      start = 1'b1; tick(); start = 1'b0;
      vectors++;
      if (error !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL restart_clears: got err=%b done=%b, expected 0 0", error, done);
      end
      for (int r = 0; r < 4; r++) begin
         drive_word(5'd3, 2'd2, 3'd5, 3'd6, 4'd1, 32'h0000_1234, 1'b1);
         bus.cfg_valid = 1'b0;
         vectors++;
         if (pe_write !== 16'h0008 || pe_config_index !== 2'd2 || pe_op !== 4'd1 ||
             pe_const !== 32'h0000_1234 || pe_input_pe_1 !== 3'd5 || pe_input_pe_2 !== 3'd6) begin
            miscompares++;
            $display("FAIL toggle_word: got pw=%h idx=%0d op=%h c=%h, expected 0008 2 1 00001234",
                     pe_write, pe_config_index, pe_op, pe_const);
         end
         tick();
         vectors++;
         if (pe_write !== 16'h0000 || pe_const !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL toggle_gap: got pw=%h c=%h, expected 0000 00001234", pe_write, pe_const);
         end
      end
      abort = 1'b1; tick(); abort = 1'b0;
      vectors++;
      if (bus.cfg_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_plain: got rdy=%b busy=%b, expected 0 0", bus.cfg_ready, busy);
      end
   endtask

   task automatic test_abort();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 10; k++) drive_k(k, 1'b1);
      abort = 1'b1;
      drive_k(10, 1'b0);
      abort = 1'b0;
      bus.cfg_valid = 1'b0;
      vectors++;
      if (bus.cfg_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          pe_config_reset !== 1'b0 || pe_write !== 16'h0000) begin
         miscompares++;
         $display("FAIL abort_with_valid: got rdy=%b busy=%b done=%b cfgrst=%b pw=%h, expected 0 0 0 0 0000",
                  bus.cfg_ready, busy, done, pe_config_reset, pe_write);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (pe_config_reset !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_%0d: got cfgrst=%b done=%b, expected 0 0", c, pe_config_reset, done);
         end
      end
   endtask

   task automatic test_reset_flush();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 64; k++) drive_k(k, 1'b1);
      bus.cfg_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({pe_write, pe_config_index, pe_input_pe_1, pe_input_pe_2, pe_op, pe_const,
           pe_config_reset, busy, done, error, bus.cfg_ready} !== 70'd0) begin
         miscompares++;
         $display("FAIL reset_in_flush: got pw=%h cfgrst=%b busy=%b done=%b rdy=%b, expected all 0",
                  pe_write, pe_config_reset, busy, done, bus.cfg_ready);
      end
      @(posedge clk); @(posedge clk);
      #3 reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if (pe_config_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_%0d: got cfgrst=%b busy=%b done=%b rdy=%b, expected 0 0 0 0",
                     c, pe_config_reset, busy, done, bus.cfg_ready);
         end
      end
      drive_k(5, 1'b0);
      bus.cfg_valid = 1'b0;
      vectors++;
      if (bus.cfg_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL no_start_no_load: got rdy=%b busy=%b, expected 0 0", bus.cfg_ready, busy);
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 64; k++) drive_k(k, 1'b1);
      bus.cfg_valid = 1'b0;
      tick();
      vectors++;
      if (pe_config_reset !== 1'b1) begin
         miscompares++;
         $display("FAIL fresh_load_pulse: got cfgrst=%b, expected 1", pe_config_reset);
      end
      tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL fresh_load_done: got done=%b, expected 1", done);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_load();
      test_bad_id();
      test_valid_toggle();
      test_abort();
      test_reset_flush();
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
